dram_wb_arbiter: RTL and testbench

- Round-robin arbiter sharing the single LiteDRAM Wishbone user port (256-bit data, 25-bit word address) between NUM_MASTERS requesters.
- Sits in the user_clk domain, between the per-requester clock-crossing FIFO front-ends and the litedram_core user_port_wishbone_0 signals.
- Provides one outstanding transaction at a time, fair grant rotation, DRAM-init gating, and a watchdog that converts hung transactions into error responses.

---
 rtl/dram_arb_pkg.sv | 25 ++
 rtl/dram_wb_arbiter_if.sv | 50 +++++
 rtl/rr_pick.sv | 35 +++
 rtl/dram_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_dram_wb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_arb_pkg.sv
`default_nettype none
//==============================================================================
// dram_arb_pkg - shared state type, default widths and packed-slice helper
// rev 1.0
//==============================================================================
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COOLDOWN = 2'd2
  } arb_state_t;

  localparam int DEFAULT_NUM_MASTERS    = 4;
  localparam int DEFAULT_WORD_SIZE      = 256;
  localparam int DEFAULT_ADDR_WIDTH     = 25;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Low bit of master idx's field inside a vector packing fields of 'width' bits.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_wb_arbiter_if.sv
`default_nettype none
//==============================================================================
// dram_wb_arbiter_if - requester-side and user-port Wishbone signals
// rev 1.0
//==============================================================================
interface dram_wb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int WORD_SIZE   = 256,
  parameter int ADDR_WIDTH  = 25,
  parameter int SEL_WIDTH   = WORD_SIZE / 8
);

  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*WORD_SIZE-1:0]  m_dat_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [WORD_SIZE-1:0]              m_dat_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;

  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [WORD_SIZE-1:0]              s_dat_o;
  logic [SEL_WIDTH-1:0]              s_sel_o;
  logic [WORD_SIZE-1:0]              s_dat_i;
  logic                              s_ack_i;
  logic                              s_err_i;

  // Arbiter view: answers the requesters, drives the user port.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  // Environment view: requesters plus the DRAM user port.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
//==============================================================================
// rr_pick - combinational round-robin picker, scans upward from last+1
// rev 1.0
//==============================================================================
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        idx        = IDX_W'(pos);
        grant[pos] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_wb_arbiter.sv
`default_nettype none
//==============================================================================
// dram_wb_arbiter - round-robin share of the LiteDRAM Wishbone user port
// rev 1.0
//==============================================================================
module dram_wb_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = DEFAULT_NUM_MASTERS,
  parameter int WORD_SIZE      = DEFAULT_WORD_SIZE,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int SEL_WIDTH      = WORD_SIZE / 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   user_clk,
  input  logic                   user_rst,
  input  logic                   initialized,
  dram_wb_arbiter_if.slave       bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);

  localparam int              IDX_W   = $clog2(NUM_MASTERS);
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       last;
  logic [WD_W-1:0]        watchdog;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [NUM_MASTERS-1:0] owner_live;

  assign req        = bus.m_cyc_i & bus.m_stb_i & {NUM_MASTERS{initialized}};
  // An owner that dropped cyc has abandoned; its response is swallowed.
  assign owner_live = grant_o & bus.m_cyc_i;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (req),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state       <= IDLE;
      last        <= IDX_W'(NUM_MASTERS - 1);
      watchdog    <= '0;
      grant_o     <= '0;
      timeout_o   <= 1'b0;
      bus.m_dat_o <= '0;
      bus.m_ack_o <= '0;
      bus.m_err_o <= '0;
      bus.s_cyc_o <= 1'b0;
      bus.s_stb_o <= 1'b0;
      bus.s_we_o  <= 1'b0;
      bus.s_adr_o <= '0;
      bus.s_dat_o <= '0;
      bus.s_sel_o <= '0;
    end else begin
      bus.m_ack_o <= '0;
      bus.m_err_o <= '0;
      timeout_o   <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_any) begin
            bus.s_cyc_o <= 1'b1;
            bus.s_stb_o <= 1'b1;
            bus.s_we_o  <= bus.m_we_i[pick_idx];
            bus.s_adr_o <= bus.m_adr_i[slice_lo(int'(pick_idx), ADDR_WIDTH) +: ADDR_WIDTH];
            bus.s_dat_o <= bus.m_dat_i[slice_lo(int'(pick_idx), WORD_SIZE) +: WORD_SIZE];
            bus.s_sel_o <= bus.m_sel_i[slice_lo(int'(pick_idx), SEL_WIDTH) +: SEL_WIDTH];
            grant_o     <= pick_grant;
            last        <= pick_idx;
            watchdog    <= '0;
            state       <= BUSY;
          end
        end

        BUSY: begin
          if (bus.s_ack_i || bus.s_err_i || watchdog == WD_LAST) begin
            bus.s_cyc_o <= 1'b0;
            bus.s_stb_o <= 1'b0;
            bus.s_we_o  <= 1'b0;
            grant_o     <= '0;
            state       <= COOLDOWN;
            // err beats ack; any slave response beats the watchdog
            if (bus.s_err_i) begin
              bus.m_err_o <= owner_live;
            end else if (bus.s_ack_i) begin
              bus.m_ack_o <= owner_live;
              bus.m_dat_o <= bus.s_dat_i;
            end else begin
              bus.m_err_o <= owner_live;
              timeout_o   <= 1'b1;
              bus.s_adr_o <= '0;
              bus.s_dat_o <= '0;
              bus.s_sel_o <= '0;
            end
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        COOLDOWN: begin
          grant_o  <= '0;
          watchdog <= '0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_wb_arbiter.sv
`default_nettype none
//==============================================================================
// tb_dram_wb_arbiter - directed and randomized checks against a reference model
// rev 1.0
//==============================================================================
module tb_dram_wb_arbiter;

  localparam int N  = 4;
  localparam int WS = 256;
  localparam int AW = 25;
  localparam int SW = WS / 8;
  localparam int T  = 16;

  logic clk         = 1'b0;
  logic rst         = 1'b1;
  logic initialized = 1'b0;
  logic [N-1:0] grant;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           model_last = N - 1;
  logic [WS-1:0] model_dat = '0;
  bit           dat_known  = 1'b1;

  // Requester-side stimulus
  logic [N-1:0]  cyc = '0;
  logic [N-1:0]  stb = '0;
  logic [N-1:0]  we  = '0;
  logic [AW-1:0] adr [N];
  logic [WS-1:0] dat [N];
  logic [SW-1:0] sel [N];

  dram_wb_arbiter_if #(.NUM_MASTERS(N), .WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

  dram_wb_arbiter #(
    .NUM_MASTERS    (N),
    .WORD_SIZE      (WS),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .user_clk    (clk),
    .user_rst    (rst),
    .initialized (initialized),
    .bus         (bus),
    .grant_o     (grant),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WS-1:0] rand_word();
    logic [WS-1:0] r;
    for (int k = 0; k < WS / 32; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(model_last + k) % N]) return (model_last + k) % N;
    return 0;
  endfunction

  task automatic rand_master(input int i);
    we[i]  = 1'($urandom_range(0, 1));
    adr[i] = AW'($urandom());
    dat[i] = rand_word();
    sel[i] = SW'($urandom());
  endtask

  task automatic drive();
    bus.m_cyc_i = cyc;
    bus.m_stb_i = stb;
    bus.m_we_i  = we;
    for (int i = 0; i < N; i++) begin
      bus.m_adr_i[i*AW +: AW] = adr[i];
      bus.m_dat_i[i*WS +: WS] = dat[i];
      bus.m_sel_i[i*SW +: SW] = sel[i];
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc = '0;
    stb = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    step();
    step();
    rst        = 1'b0;
    model_last = N - 1;
    model_dat  = '0;
    dat_known  = 1'b1;
  endtask

  // One transaction starting from an IDLE cycle; returns in the following IDLE cycle.
  // kind: 0 ack, 1 err, 2 no response (watchdog), 3 ack and err together.
  task automatic run_txn(input logic [N-1:0] mask, input int kind, input int lat,
                         input bit abandon, input bit fixed, input logic [WS-1:0] rd,
                         input bit drop_init, output logic [N-1:0] g);
    int            w;
    int            cnt;
    logic [N-1:0]  oh;
    logic [N-1:0]  exp_resp;
    logic          e_we;
    logic [AW-1:0] e_adr;
    logic [WS-1:0] e_dat;
    logic [SW-1:0] e_sel;
    if (!fixed)
      for (int i = 0; i < N; i++) if (mask[i]) rand_master(i);
    cyc      = mask;
    stb      = mask;
    w        = model_pick(mask);
    oh       = N'(1) << w;
    exp_resp = abandon ? '0 : oh;
    e_we     = we[w];
    e_adr    = adr[w];
    e_dat    = dat[w];
    e_sel    = sel[w];
    step();
    g = grant;
    chk("grant", grant, oh);
    chk("s_stb_rise", bus.s_stb_o, 1'b1);
    chk("s_cyc_rise", bus.s_cyc_o, 1'b1);
    chk("s_we", bus.s_we_o, e_we);
    chk("s_adr", bus.s_adr_o, e_adr);
    chk("s_dat", bus.s_dat_o, e_dat);
    chk("s_sel", bus.s_sel_o, e_sel);
    model_last = w;
    // Winner's inputs change after capture and must not reach the port
    rand_master(w);
    if (abandon) begin
      cyc[w] = 1'b0;
      stb[w] = 1'b0;
    end
    if (drop_init) initialized = 1'b0;
    if (kind == 2) begin
      cnt = 1;
      while (bus.s_stb_o === 1'b1 && cnt < 4 * T) begin
        step();
        if (bus.s_stb_o === 1'b1) cnt++;
      end
      chk("stb_high_cycles", cnt, T);
      chk("timeout_err", bus.m_err_o, exp_resp);
      chk("timeout_pulse", timeout, 1'b1);
      chk("timeout_no_ack", bus.m_ack_o, '0);
    end else begin
      repeat (lat) step();
      chk("hold_adr", bus.s_adr_o, e_adr);
      chk("hold_stb", bus.s_stb_o, 1'b1);
      bus.s_dat_i = rd;
      bus.s_ack_i = (kind != 1);
      bus.s_err_i = (kind != 0);
      step();
      bus.s_ack_i = 1'b0;
      bus.s_err_i = 1'b0;
      bus.s_dat_i = rand_word();
      chk("no_timeout", timeout, 1'b0);
      if (kind == 0) begin
        chk("ack", bus.m_ack_o, exp_resp);
        chk("ack_no_err", bus.m_err_o, '0);
        if (!abandon) chk("rdata", bus.m_dat_o, rd);
        model_dat = rd;
        dat_known = !abandon;
      end else begin
        chk("err", bus.m_err_o, exp_resp);
        chk("err_no_ack", bus.m_ack_o, '0);
        if (dat_known) chk("err_keeps_dat", bus.m_dat_o, model_dat);
      end
    end
    chk("s_cyc_drop", bus.s_cyc_o, 1'b0);
    chk("s_stb_drop", bus.s_stb_o, 1'b0);
    chk("grant_clear", grant, '0);
    step();
    chk("ack_one_cycle", bus.m_ack_o, '0);
    chk("err_one_cycle", bus.m_err_o, '0);
    chk("no_arb_in_cooldown", bus.s_stb_o, 1'b0);
    chk("timeout_one_cycle", timeout, 1'b0);
  endtask

  initial begin
    logic [N-1:0]  g;
    logic [WS-1:0] rd;
    logic [N-1:0]  mask;
    int            r;
    int            kind;
    for (int i = 0; i < N; i++) begin
      adr[i] = '0;
      dat[i] = '0;
      sel[i] = '0;
    end
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;

    do_reset();
    chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
    chk("rst_s_stb", bus.s_stb_o, 1'b0);
    chk("rst_grant", grant, '0);
    chk("rst_m_ack", bus.m_ack_o, '0);
    chk("rst_m_err", bus.m_err_o, '0);
    chk("rst_m_dat", bus.m_dat_o, '0);
    chk("rst_timeout", timeout, 1'b0);

    // Requests pending while DRAM not initialized: nothing is granted
    cyc = '1;
    stb = '1;
    repeat (4) begin
      step();
      chk("gated_s_cyc", bus.s_cyc_o, 1'b0);
      chk("gated_grant", grant, '0);
    end
    initialized = 1'b1;
    run_txn(4'hF, 0, 1, 1'b0, 1'b0, rand_word(), 1'b0, g);
    chk("init_first_m0", g, 4'b0001);

    // Master 2 write, ack three cycles after stb
    do_reset();
    we[2]  = 1'b1;
    adr[2] = 25'h0000123;
    dat[2] = {32{8'hA5}};
    sel[2] = '1;
    run_txn(4'b0100, 0, 3, 1'b0, 1'b1, rand_word(), 1'b0, g);
    chk("m2_grant", g, 4'b0100);

    // Master 1 read returning a known word
    we[1]  = 1'b0;
    adr[1] = AW'($urandom());
    dat[1] = rand_word();
    sel[1] = '1;
    rd     = {16'hDEAD, {14{16'h5A5A}}, 16'hBEEF};
    run_txn(4'b0010, 0, 2, 1'b0, 1'b1, rd, 1'b0, g);
    chk("m1_grant", g, 4'b0010);

    // Continuous requests from reset rotate 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_txn(4'hF, 0, $urandom_range(0, 3), 1'b0, 1'b0, rand_word(), 1'b0, g);
      chk("rr_order", g, N'(1) << (k % N));
    end

    // Watchdog expiry, then the next requester is served normally
    run_txn(4'b0100, 2, 0, 1'b0, 1'b0, rand_word(), 1'b0, g);
    run_txn(4'b0011, 0, 1, 1'b0, 1'b0, rand_word(), 1'b0, g);
    chk("after_timeout_grant", g, 4'b0001);

    // Ack in the last watchdog cycle wins over the timeout
    run_txn(4'b0100, 0, T - 1, 1'b0, 1'b0, rand_word(), 1'b0, g);

    // Ack and err together are reported as err
    run_txn(4'b1000, 3, 2, 1'b0, 1'b0, rand_word(), 1'b0, g);

    // Master 3 abandons mid-transaction; the arbiter moves on to master 0
    run_txn(4'b1000, 0, 2, 1'b1, 1'b0, rand_word(), 1'b0, g);
    run_txn(4'hF, 0, 0, 1'b0, 1'b0, rand_word(), 1'b0, g);
    chk("after_abandon_m0", g, 4'b0001);

    // initialized drops during BUSY: transaction completes, no new grant until it returns
    run_txn(4'b0110, 0, 2, 1'b0, 1'b0, rand_word(), 1'b1, g);
    repeat (3) begin
      step();
      chk("init_low_no_grant", bus.s_cyc_o, 1'b0);
    end
    initialized = 1'b1;
    run_txn(4'b0110, 1, 1, 1'b0, 1'b0, rand_word(), 1'b0, g);

    // Reset in the middle of a transaction
    cyc = 4'b0100;
    stb = 4'b0100;
    step();
    chk("pre_rst_busy", bus.s_stb_o, 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_s_cyc", bus.s_cyc_o, 1'b0);
    chk("midrst_s_stb", bus.s_stb_o, 1'b0);
    chk("midrst_s_adr", bus.s_adr_o, '0);
    chk("midrst_s_dat", bus.s_dat_o, '0);
    chk("midrst_grant", grant, '0);
    chk("midrst_m_dat", bus.m_dat_o, '0);
    rst        = 1'b0;
    cyc        = '0;
    stb        = '0;
    model_last = N - 1;
    model_dat  = '0;
    dat_known  = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      r    = $urandom_range(0, 9);
      kind = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 3 : 2;
      run_txn(mask, kind, $urandom_range(0, 5), ($urandom_range(0, 5) == 0),
              1'b0, rand_word(), 1'b0, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
